// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared note-length constants, divisor table and encoder state type
package note_pkg;

  // Default width of the tempo input and the duration counter
  localparam int CNT_W_DEFAULT = 64;

  // Divisor per length code: code k lasts floor(4*cycles_per_beat / LEN_DIV[k]).
  // The first element listed is index 15, the last is index 0.
  localparam logic [15:0][6:0] LEN_DIV = {
    7'd64, 7'd32, 7'd24, 7'd16, 7'd15, 7'd12, 7'd10, 7'd9,
    7'd8,  7'd7,  7'd6,  7'd5,  7'd4,  7'd3,  7'd2,  7'd1
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    SEARCH  = 2'd2
  } enc_state_t;

endpackage

// File: rtl/length_divisor_lut.sv
// rtl/length_divisor_lut.sv - combinational length code to divisor lookup
module length_divisor_lut
  import note_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] divisor
);

  assign divisor = LEN_DIV[code];

endmodule

// File: rtl/note_length_encoder.sv
// rtl/note_length_encoder.sv - measures a held note and quantizes it to a length code
module note_length_encoder
  import note_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             note_on,
  input  logic [CNT_W-1:0] cycles_per_beat,
  output logic             busy,
  output logic             code_valid,
  output logic [3:0]       code,
  output logic             too_short
);

  // Product (dur+1)*D needs CNT_W+1 bits times 7 bits; keep the full width
  localparam int WIDE_W = CNT_W + 8;

  enc_state_t       state;
  logic             note_on_q;
  logic [CNT_W-1:0] dur;
  logic [3:0]       k;
  logic [CNT_W+1:0] target;
  logic [6:0]       divisor;

  logic [WIDE_W-1:0] dur_ext;
  logic [WIDE_W-1:0] div_ext;
  logic [WIDE_W-1:0] product;
  logic [WIDE_W-1:0] target_ext;
  logic              hit;

  length_divisor_lut u_lut (
    .code    (k),
    .divisor (divisor)
  );

  // Candidate k matches when floor(T/D[k]) <= dur, i.e. T < (dur+1)*D[k]
  always_comb begin
    dur_ext    = WIDE_W'(dur) + WIDE_W'(1);
    div_ext    = WIDE_W'(divisor);
    product    = dur_ext * div_ext;
    target_ext = WIDE_W'(target);
    hit        = (target_ext < product);
  end

  // Edge detect, duration counter and sequential code search with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      note_on_q  <= 1'b0;
      dur        <= '0;
      k          <= 4'd0;
      target     <= '0;
      busy       <= 1'b0;
      code_valid <= 1'b0;
      code       <= 4'd0;
      too_short  <= 1'b0;
    end else begin
      note_on_q  <= note_on;
      code_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Only a fresh rising edge starts a measurement; a held level is ignored
          if (note_on && !note_on_q) begin
            state <= MEASURE;
            dur   <= CNT_W'(1);
            busy  <= 1'b1;
          end
        end
        MEASURE: begin
          if (note_on) begin
            if (dur != '1) begin
              dur <= dur + CNT_W'(1);
            end
          end else begin
            // Tempo is frozen here; later changes cannot disturb the search
            target <= {cycles_per_beat, 2'b00};
            k      <= 4'd0;
            state  <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            code       <= k;
            too_short  <= 1'b0;
            code_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (k == 4'd15) begin
            code       <= 4'd15;
            too_short  <= 1'b1;
            code_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            k <= k + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
